rv32i_fetch: RTL and testbench
==============================

// Module: rv32i_fetch
// PURPOSE
// Instruction fetch stage directly upstream of the RV32I decoder. Owns the PC and
// issues word reads to instruction memory. Buffers returned words with their PCs in an
// in-order queue. Presents {instr, pc} to decode over a valid/ready handshake.
// Branch/jump resolution downstream redirects the PC and flushes all fetched-but-unused work.
// PARAMETERS
// RESET_PC    32'h0000_0000  PC of first fetch after reset (bits [1:0] must be 0)
// DEPTH       4              instr queue entries = max in-flight + buffered words (>=2, pow2)
// PORTS
// clk             in   1   rising-edge clock
// rst_n           in   1   asynchronous active-low reset
// imem_req_valid  out  1   fetch request valid
// imem_req_ready  in   1   memory accepts request this cycle
// imem_req_addr   out  32  word-aligned fetch address
// imem_rsp_valid  in   1   read data valid (in order, >=1 cycle after accept, no backpressure)
// imem_rsp_data   in   32  instruction word
// redirect_valid  in   1   PC redirect (taken branch / JAL / JALR) from downstream
// redirect_pc     in   32  new PC; bits [1:0] ignored (treated as 0)
// dec_valid       out  1   dec_instr/dec_pc valid to decoder
// dec_ready       in   1   decoder consumes this cycle
// dec_instr       out  32  instruction word
// dec_pc          out  32  PC of dec_instr
// BEHAVIOUR
// - Reset (async assert, sync deassert): pc=RESET_PC, queue empty, inflight=0, drop=0.
//   All outputs 0: imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc.
// - Request: imem_req_valid=1 when (inflight+count) < DEPTH and no redirect this cycle.
//   imem_req_addr=pc. On valid&&ready: pc<=pc+4 (wraps mod 2^32); inflight++.
//   Per-slot PC is recorded at issue.
// - Addr/valid held stable while valid&&!ready, except redirect may withdraw/replace.
// - Response: imem_rsp_valid with drop>0 -> discard, drop--.
//   Otherwise push {data, recorded PC} into the queue and inflight--.
//   rsp_valid with inflight==0 and drop==0 is ignored (protocol error, no state change).
// - Decode side: dec_valid = queue non-empty (registered head, no combinational path from
//   rsp). Pop on dec_valid&&dec_ready. dec_* held stable while valid&&!ready.
//   Latency: memory rsp at cycle t -> dec_valid at t+1.
// - Same-cycle push and pop allowed; count unchanged. Credit check uses registered count.
//   Steady state 1 instr/cycle with 1-cycle memory and dec_ready=1 when DEPTH>=3.
// - Redirect (highest priority):
//   - pc <= {redirect_pc[31:2],2'b00}
//   - queue flushed
//   - dec_valid=0 next cycle
//   - drop <= drop + inflight (minus 1 if a rsp that is not dropped arrives the same cycle;
//     that rsp is also discarded)
//   - inflight <= 0
//   - no request issued that cycle; first request to new PC the following cycle
//   - a pop by decode in the redirect cycle is still valid (that instr was consumed)
// - Back-to-back redirects: last one wins; drop accumulates. Requests resume only when
//   drop+inflight+count < DEPTH.
// - Reset mid-operation: all state cleared immediately. Late memory responses after reset
//   are the memory's responsibility (memory is reset by the same rst_n).
// - Counters inflight, count, drop sized $clog2(DEPTH)+1; never exceed DEPTH (assertion).
// TESTING
// 1 Reset: rst_n=0 -> all outputs 0. Release -> next cycle req_valid=1, addr=0x0.
// 2 Stream, 1-cycle mem, dec_ready=1: words at 0x0,0x4,0x8,0xC -> dec_pc 0,4,8,C on
//   consecutive cycles, instr matches mem.
// 3 Backpressure: dec_ready=0 for 10 cycles -> exactly DEPTH requests issued.
//   dec_instr/dec_pc held. Release -> remaining words drain in order, no loss/dup.
// 4 Redirect with 2 in flight, mem latency 3: redirect_pc=0x100 -> both old rsps dropped.
//   Next dec_pc=0x100, then 0x104.
// 5 Redirect same cycle as rsp_valid and dec pop; redirect_pc=0x203 -> popped instr counted
//   once. Rsp discarded. Fetch addr 0x200.
// 6 Assert rst_n=0 mid-stream with full queue -> outputs 0 asynchronously.
//   After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: owns the PC, issues word reads, buffers in-order responses
// with their PCs and hands {instr, pc} to decode; redirects flush and drop stale work.
module rv32i_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam int            SW      = CW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_alloc_ptr;
    logic [AW-1:0] r_fill_ptr;
    logic [AW-1:0] r_head_ptr;
    logic          r_active;
    logic [31:0]   r_slot_pc    [DEPTH];
    logic [31:0]   r_slot_instr [DEPTH];

    logic [SW-1:0] w_occupancy;
    logic          w_credit;
    logic          w_issue;
    logic          w_rsp_drop;
    logic          w_rsp_take;
    logic          w_push;
    logic          w_pop;

    // Stale responses still hold a slot of credit until they drain, so drop counts too.
    assign w_occupancy = SW'(r_drop) + SW'(r_inflight) + SW'(r_count);
    assign w_credit    = w_occupancy < SW'(DEPTH);

    assign imem_req_valid = r_active && w_credit && !redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_issue        = imem_req_valid && imem_req_ready;

    assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
    assign w_rsp_take = imem_rsp_valid && (r_drop == '0) && (r_inflight != '0);
    assign w_push     = w_rsp_take && !redirect_valid;

    assign dec_valid = (r_count != '0);
    assign dec_instr = dec_valid ? r_slot_instr[r_head_ptr] : 32'h0;
    assign dec_pc    = dec_valid ? r_slot_pc[r_head_ptr]    : 32'h0;
    assign w_pop     = dec_valid && dec_ready;

    // Slot i gets its PC at issue and its word at response; pointers advance in lockstep order.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_slot_pc[r_alloc_ptr] <= r_pc;
        end
        if (w_push) begin
            r_slot_instr[r_fill_ptr] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_inflight  <= '0;
            r_count     <= '0;
            r_drop      <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_active    <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (redirect_valid) begin
                r_pc        <= {redirect_pc[31:2], 2'b00};
                r_inflight  <= '0;
                r_count     <= '0;
                r_alloc_ptr <= '0;
                r_fill_ptr  <= '0;
                r_head_ptr  <= '0;
                // A response arriving now belongs to the old path and is discarded either way.
                r_drop      <= r_drop + r_inflight - CW'(w_rsp_take) - CW'(w_rsp_drop);
            end else begin
                if (w_issue) begin
                    r_pc        <= r_pc + 32'd4;
                    r_alloc_ptr <= r_alloc_ptr + AW'(1);
                end
                if (w_push) begin
                    r_fill_ptr <= r_fill_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_head_ptr <= r_head_ptr + AW'(1);
                end
                r_inflight <= r_inflight + CW'(w_issue) - CW'(w_rsp_take);
                r_count    <= r_count + CW'(w_push) - CW'(w_pop);
                r_drop     <= r_drop - CW'(w_rsp_drop);
            end
        end
    end

    a_counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        (r_inflight <= DEPTH_C) && (r_count <= DEPTH_C) && (r_drop <= DEPTH_C));

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: queue-level model of the fetch pipeline checked every cycle,
// plus directed scenarios with hand-computed PC sequences.
module tb_rv32i_fetch;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    rv32i_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Memory environment: in-order, fixed latency per segment
    int          lat = 1;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          mem_last_due = -1;
    int          issue_cnt = 0;

    // Model: PCs awaiting response, buffered {pc, instr}, pending drops, next fetch PC
    logic [31:0] m_pc;
    logic [31:0] m_if_q[$];
    logic [31:0] m_buf_pc[$];
    logic [31:0] m_buf_instr[$];
    int          m_drop;

    // Observation log of what decode actually consumed
    logic [31:0] pop_log[$];
    int          pop_cyc[$];
    logic        obs_req_valid;
    logic [31:0] obs_req_addr;
    logic        obs_dec_fire;
    logic [31:0] obs_dec_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0013_0000 ^ {a[23:0], 8'h93};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_clear();
        m_pc = 32'h0000_0000;
        m_if_q.delete();
        m_buf_pc.delete();
        m_buf_instr.delete();
        m_drop = 0;
        mem_addr_q.delete();
        mem_due_q.delete();
        mem_last_due = -1;
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step(input logic d_rdy, input logic q_rdy,
                        input logic redir = 1'b0, input logic [31:0] rpc = 32'h0);
        logic        exp_req;
        logic [31:0] p;
        int          due;
        @(negedge clk);
        dec_ready      = d_rdy;
        imem_req_ready = q_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q[0]);
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        exp_req = !redir && ((m_drop + m_if_q.size() + m_buf_pc.size()) < DEPTH);
        chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_req});
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        chk("dec_valid", {31'h0, dec_valid}, {31'h0, m_buf_pc.size() > 0});
        if (m_buf_pc.size() > 0) begin
            chk("dec_pc", dec_pc, m_buf_pc[0]);
            chk("dec_instr", dec_instr, m_buf_instr[0]);
        end
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_dec_fire  = dec_valid && dec_ready;
        obs_dec_pc    = dec_pc;
        if (imem_req_valid && imem_req_ready) begin
            due = cycle + lat;
            if (due <= mem_last_due) due = mem_last_due + 1;
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(due);
            mem_last_due = due;
            issue_cnt++;
        end
        if (dec_valid && dec_ready) begin
            pop_log.push_back(dec_pc);
            pop_cyc.push_back(cycle);
        end
        if (m_buf_pc.size() > 0 && d_rdy) begin
            void'(m_buf_pc.pop_front());
            void'(m_buf_instr.pop_front());
        end
        if (imem_rsp_valid) begin
            if (m_drop > 0) begin
                m_drop--;
            end else if (m_if_q.size() > 0) begin
                p = m_if_q.pop_front();
                if (!redir) begin
                    m_buf_pc.push_back(p);
                    m_buf_instr.push_back(imem_rsp_data);
                end
            end
        end
        if (redir) begin
            m_drop += m_if_q.size();
            m_if_q.delete();
            m_buf_pc.delete();
            m_buf_instr.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if (exp_req && q_rdy) begin
            m_if_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        cycle++;
    endtask

    // Reset: mid=1 asserts rst_n away from any clock edge to show the async path.
    task automatic do_reset(input bit mid);
        if (mid) #2;
        else @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;
        model_clear();
        #1;
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        pop_log.delete();
        pop_cyc.delete();
        issue_cnt = 0;
    endtask

    initial begin
        int          base;
        int          n;
        logic [31:0] p;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        model_clear();

        // 1: reset values, first request to RESET_PC
        do_reset(1'b0);
        lat = 1;
        step(1'b1, 1'b1);
        chk("t1_first_req_valid", {31'h0, obs_req_valid}, 32'h1);
        chk("t1_first_req_addr", obs_req_addr, 32'h0);

        // 2: streaming with 1-cycle memory, one instruction per cycle
        repeat (11) step(1'b1, 1'b1);
        chk("t2_pop_count", pop_log.size(), 32'd10);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pc_seq", pop_log[i], 32'(i * 4));
            chk("t2_consecutive", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        end

        // 3: decode backpressure, credit stops at DEPTH, head held, then drain in order
        do_reset(1'b0);
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            if (i >= 2) chk("t3_hold_pc", obs_dec_pc, 32'h0);
        end
        chk("t3_issue_count", issue_cnt, DEPTH);
        chk("t3_hold_instr", dec_instr, mem_word(32'h0));
        repeat (14) step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) chk("t3_drain_seq", pop_log[i], 32'(i * 4));

        // Request-side stall: address must hold while valid && !ready
        lat = 2;
        for (int i = 0; i < 15; i++) step(1'b1, (i % 3) != 0);
        repeat (6) step(1'b1, 1'b1);

        // 4: redirect with two requests in flight, latency 3
        do_reset(1'b0);
        lat = 3;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        chk("t4_no_pop_before", pop_log.size(), 32'd0);
        repeat (10) step(1'b1, 1'b1);
        chk("t4_first_pc", pop_log[0], 32'h0000_0100);
        chk("t4_second_pc", pop_log[1], 32'h0000_0104);

        // Back-to-back redirects: the last target wins
        step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        base = pop_log.size();
        repeat (12) step(1'b1, 1'b1);
        chk("t4_b2b_pc", pop_log[base], 32'h0000_0400);
        chk("t4_b2b_next", pop_log[base + 1], 32'h0000_0404);

        // 5: redirect in the same cycle as a live response and a decode pop
        do_reset(1'b0);
        lat = 1;
        repeat (6) step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        chk("t5_pop_in_redirect", {31'h0, obs_dec_fire}, 32'h1);
        chk("t5_pop_pc", obs_dec_pc, 32'h0000_0010);
        p    = obs_dec_pc;
        base = pop_log.size();
        step(1'b1, 1'b1);
        chk("t5_req_valid", {31'h0, obs_req_valid}, 32'h1);
        chk("t5_req_addr", obs_req_addr, 32'h0000_0200);
        repeat (6) step(1'b1, 1'b1);
        n = 0;
        foreach (pop_log[i]) if (pop_log[i] == p) n++;
        chk("t5_popped_once", n, 32'd1);
        chk("t5_next_pc", pop_log[base], 32'h0000_0200);

        // 6: asynchronous reset with a full queue, then restart at RESET_PC
        do_reset(1'b0);
        lat = 1;
        repeat (6) step(1'b0, 1'b1);
        chk("t6_full_valid", {31'h0, dec_valid}, 32'h1);
        do_reset(1'b1);
        step(1'b1, 1'b1);
        chk("t6_restart_valid", {31'h0, obs_req_valid}, 32'h1);
        chk("t6_restart_addr", obs_req_addr, 32'h0);
        repeat (5) step(1'b1, 1'b1);
        chk("t6_first_pc", pop_log[0], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
